// File: rtl/npc_ctrl_pkg.sv
// Shared datapath definitions for the next-PC controller: FSM encodings,
// reset vector and small address helpers.
package npc_ctrl_pkg;

  typedef logic [31:2] waddr_t;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT     = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  localparam waddr_t RESET_VECTOR = 30'h00000C00;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_JR     = 2'd2,
    SRC_BRANCH = 2'd3
  } npc_src_e;

  // Sequential successor; wraps modulo 2^30 by construction.
  function automatic waddr_t pc_inc(input waddr_t pc);
    return pc + 30'd1;
  endfunction

  // j/jal keep the top four address bits of the current PC.
  function automatic waddr_t jump_addr(input waddr_t pc, input logic [25:0] idx);
    return {pc[31:28], idx};
  endfunction

endpackage

// File: rtl/npc_ctrl_sat_cnt.sv
// Saturating up-counter used for the branch-bubble performance statistic.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/npc_ctrl.sv
// Next-PC selection with a branch wait/redirect FSM, watchdog abort and
// a bubble counter.
module npc_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:2]      PC,
  input  logic             hazard,
  input  logic             br_decode,
  input  logic             br_resolve,
  input  logic             br_taken,
  input  logic [31:2]      br_target,
  input  logic             j_valid,
  input  logic [25:0]      j_index,
  input  logic             jr_valid,
  input  logic [31:2]      jr_target,
  output logic [31:2]      NPC,
  output logic             BranchBubble,
  output logic             wd_err,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  logic [1:0] state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic       taken_reg, taken_next;
  waddr_t     target_reg, target_next;
  logic       wd_err_reg, wd_err_next;
  npc_src_e   npc_src;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      taken_reg    <= 1'b0;
      target_reg   <= '0;
      wd_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      taken_reg    <= taken_next;
      target_reg   <= target_next;
      wd_err_reg   <= wd_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    taken_next    = taken_reg;
    target_next   = target_reg;
    wd_err_next   = wd_err_reg;
    case (state_reg)
      IDLE: begin
        wait_cnt_next = '0;
        if (br_decode && !hazard) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A resolve on the final permitted cycle still beats the watchdog.
        if (br_resolve) begin
          state_next    = REDIRECT;
          taken_next    = br_taken;
          target_next   = br_target;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next    = IDLE;
          wd_err_next   = 1'b1;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      REDIRECT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A branch in ID masks any jump presented alongside it.
  always_comb begin
    npc_src = SRC_SEQ;
    if (!Reset) begin
      case (state_reg)
        IDLE: begin
          if (!br_decode) begin
            if (jr_valid) begin
              npc_src = SRC_JR;
            end else if (j_valid) begin
              npc_src = SRC_JUMP;
            end
          end
        end
        REDIRECT: begin
          if (taken_reg) begin
            npc_src = SRC_BRANCH;
          end
        end
        default: begin
          npc_src = SRC_SEQ;
        end
      endcase
    end
  end

  always_comb begin
    case (npc_src)
      SRC_JR:     NPC = jr_target;
      SRC_JUMP:   NPC = jump_addr(PC, j_index);
      SRC_BRANCH: NPC = target_reg;
      default:    NPC = pc_inc(PC);
    endcase
  end

  assign BranchBubble = (state_reg == WAIT);
  assign wd_err       = wd_err_reg;

  sat_cnt #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .inc   (state_reg == WAIT),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_npc_ctrl.sv
// Scoreboard bench for npc_ctrl: expectations are queued as each cycle's
// stimulus is applied and drained against the outputs at the falling edge.
module tb_npc_ctrl;

  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [31:2]      PC;
  logic             hazard;
  logic             br_decode;
  logic             br_resolve;
  logic             br_taken;
  logic [31:2]      br_target;
  logic             j_valid;
  logic [25:0]      j_index;
  logic             jr_valid;
  logic [31:2]      jr_target;
  logic [31:2]      NPC;
  logic             BranchBubble;
  logic             wd_err;
  logic [CNT_W-1:0] bubble_cnt;

  npc_ctrl #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PC          (PC),
    .hazard      (hazard),
    .br_decode   (br_decode),
    .br_resolve  (br_resolve),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .j_valid     (j_valid),
    .j_index     (j_index),
    .jr_valid    (jr_valid),
    .jr_target   (jr_target),
    .NPC         (NPC),
    .BranchBubble(BranchBubble),
    .wd_err      (wd_err),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;
  logic exp_wd   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0:       return {2'b00, NPC};
      1:       return {31'd0, BranchBubble};
      2:       return {31'd0, wd_err};
      default: return 32'(bubble_cnt);
    endcase
  endfunction

  task automatic expect_all(input string tag, input logic [31:2] npc, input logic bb);
    sb_q.push_back('{$sformatf("%s.npc", tag), 0, {2'b00, npc}});
    sb_q.push_back('{$sformatf("%s.bb", tag), 1, {31'd0, bb}});
    sb_q.push_back('{$sformatf("%s.wd", tag), 2, {31'd0, exp_wd}});
    sb_q.push_back('{$sformatf("%s.cnt", tag), 3, 32'(exp_cnt)});
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.kind), e.val);
    end
  endtask

  task automatic clear_inputs();
    hazard     = 1'b0;
    br_decode  = 1'b0;
    br_resolve = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    j_valid    = 1'b0;
    j_index    = '0;
    jr_valid   = 1'b0;
    jr_target  = '0;
  endtask

  // One clock cycle: inputs are already applied at posedge+1.
  task automatic step(input string tag, input logic [31:2] npc, input logic bb);
    expect_all(tag, npc, bb);
    @(negedge Clk);
    drain();
    $display("%-12s pc=%h npc=%h bb=%b wd=%b cnt=%0d", tag, PC, NPC, BranchBubble, wd_err, bubble_cnt);
    if (bb) exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
    @(posedge Clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset(input string tag, input logic [31:2] npc);
    Reset = 1'b1;
    #1;
    exp_cnt = 0;
    exp_wd  = 1'b0;
    expect_all(tag, npc, 1'b0);
    drain();
    $display("%-12s pc=%h npc=%h bb=%b wd=%b cnt=%0d", tag, PC, NPC, BranchBubble, wd_err, bubble_cnt);
    #1 Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0;
    PC    = 30'hC00;
    clear_inputs();
    #1 Reset = 1'b1;
    jr_valid  = 1'b1;
    jr_target = 30'h1234;
    #2;
    expect_all("in_reset", 30'hC01, 1'b0);
    drain();
    #1 Reset = 1'b0;
    clear_inputs();
    @(posedge Clk);
    #1;

    step("rst_idle", 30'hC01, 1'b0);

    // Taken branch, two WAIT cycles
    PC = 30'hC04; br_decode = 1'b1;
    step("br_dec", 30'hC05, 1'b0);
    step("br_w1", 30'hC05, 1'b1);
    br_resolve = 1'b1; br_taken = 1'b1; br_target = 30'hC40;
    step("br_w2", 30'hC05, 1'b1);
    br_resolve = 1'b1; br_taken = 1'b0; br_target = 30'h999;
    step("br_redir", 30'hC40, 1'b0);
    PC = 30'hC40; br_resolve = 1'b1; br_taken = 1'b1; br_target = 30'h777;
    step("br_idle_res", 30'hC41, 1'b0);
    PC = 30'hC41;
    step("br_idle2", 30'hC42, 1'b0);

    // Hazard delays WAIT entry; not-taken resolve
    PC = 30'hC08; br_decode = 1'b1; hazard = 1'b1;
    step("hz_hold", 30'hC09, 1'b0);
    br_decode = 1'b1; j_valid = 1'b1; j_index = 26'h3; jr_valid = 1'b1; jr_target = 30'h555;
    step("hz_go", 30'hC09, 1'b0);
    hazard = 1'b1; br_decode = 1'b1; jr_valid = 1'b1; jr_target = 30'h555;
    br_resolve = 1'b1; br_taken = 1'b0; br_target = 30'hC80;
    step("hz_w1", 30'hC09, 1'b1);
    hazard = 1'b1; jr_valid = 1'b1; jr_target = 30'h555;
    step("hz_redir", 30'hC09, 1'b0);
    step("hz_idle", 30'hC09, 1'b0);

    // Jump priority
    PC = 30'h3000C00; j_valid = 1'b1; j_index = 26'h100; jr_valid = 1'b1; jr_target = 30'h1234;
    step("jr_pri", 30'h1234, 1'b0);
    j_valid = 1'b1; j_index = 26'h100;
    step("j_only", 30'h0000100, 1'b0);
    PC = 30'h2C000000; j_valid = 1'b1; j_index = 26'h100;
    step("j_hi", 30'h2C000100, 1'b0);

    // Watchdog abort after MAX_WAIT cycles
    PC = 30'hD00; br_decode = 1'b1;
    step("wd_dec", 30'hD01, 1'b0);
    for (int i = 1; i <= MAX_WAIT; i++) step($sformatf("wd_w%0d", i), 30'hD01, 1'b1);
    exp_wd = 1'b1;
    step("wd_abort", 30'hD01, 1'b0);
    step("wd_sticky", 30'hD01, 1'b0);
    do_reset("wd_reset", 30'hD01);

    // Resolve on the last permitted cycle wins
    PC = 30'hE00; br_decode = 1'b1;
    step("wr_dec", 30'hE01, 1'b0);
    for (int i = 1; i < MAX_WAIT; i++) step($sformatf("wr_w%0d", i), 30'hE01, 1'b1);
    br_resolve = 1'b1; br_taken = 1'b1; br_target = 30'hF00;
    step("wr_wlast", 30'hE01, 1'b1);
    step("wr_redir", 30'hF00, 1'b0);
    step("wr_idle", 30'hE01, 1'b0);

    // Counter saturation via a second abort
    br_decode = 1'b1;
    step("sat_dec", 30'hE01, 1'b0);
    for (int i = 1; i <= MAX_WAIT; i++) step($sformatf("sat_w%0d", i), 30'hE01, 1'b1);
    exp_wd = 1'b1;
    step("sat_abort", 30'hE01, 1'b0);

    // Minimum latency: resolve in the first WAIT cycle
    br_decode = 1'b1;
    step("min_dec", 30'hE01, 1'b0);
    br_resolve = 1'b1; br_taken = 1'b1; br_target = 30'h3FFFFFF0;
    step("min_w1", 30'hE01, 1'b1);
    step("min_redir", 30'h3FFFFFF0, 1'b0);

    // PC wrap, then asynchronous reset in the middle of WAIT
    PC = 30'h3FFFFFFF;
    step("wrap", 30'h0, 1'b0);
    br_decode = 1'b1;
    step("rw_dec", 30'h0, 1'b0);
    #2;
    expect_all("rw_wait", 30'h0, 1'b1);
    drain();
    do_reset("rw_reset", 30'h0);
    step("post_rst", 30'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/npc_ctrl.md
NPC_CTRL -- requirements
Module: npc_ctrl

Interface
REQ-001 Parameter MAX_WAIT, 8, maximum WAIT cycles before watchdog abort (legal range 1..15).
REQ-002 Parameter CNT_W, 16, width of the bubble performance counter.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 PC  input  [31:2]  current word-address PC from the PC register.
REQ-006 hazard  input  1  load-use stall; PC register holds this cycle.
REQ-007 br_decode  input  1  conditional branch present in ID this cycle.
REQ-008 br_resolve  input  1  branch outcome valid from EX this cycle.
REQ-009 br_taken  input  1  branch outcome, qualified by br_resolve.
REQ-010 br_target  input  [31:2]  branch target word address, qualified by br_resolve.
REQ-011 j_valid  input  1  j/jal in ID this cycle.
REQ-012 j_index  input  [25:0]  instr_index field of the jump.
REQ-013 jr_valid  input  1  jr in ID with forwarded register value.
REQ-014 jr_target  input  [31:2]  jr destination word address.
REQ-015 NPC  output  [31:2]  next PC to the PC register (combinational).
REQ-016 BranchBubble  output  1  freezes the PC register while a branch is unresolved.
REQ-017 wd_err  output  1  sticky watchdog-abort flag.
REQ-018 bubble_cnt  output  [CNT_W-1:0]  saturating count of cycles with BranchBubble=1.

Function
REQ-019 FSM states shall be IDLE, WAIT, REDIRECT; BranchBubble shall be 1 only in WAIT (Moore output).
REQ-020 In IDLE, NPC shall be, by priority: jr_target if jr_valid; else {PC[31:28], j_index} if j_valid; else PC+1.
REQ-021 PC+1 shall be 30-bit modular: 30'h3FFFFFFF+1 = 30'h0.
REQ-022 IDLE->WAIT when br_decode=1 and hazard=0; if hazard=1, the FSM shall stay in IDLE and re-sample next cycle.
REQ-023 br_decode shall take priority over simultaneous j_valid/jr_valid; the jump inputs shall then be ignored.
REQ-024 In WAIT, NPC shall be PC+1 (value unused, PC frozen), and a wait counter shall increment each cycle.
REQ-025 WAIT->REDIRECT on br_resolve=1; br_taken and br_target shall be captured into internal registers on that edge.
REQ-026 WAIT->IDLE when the wait counter reaches MAX_WAIT without br_resolve; wd_err shall set and remain set until Reset.
REQ-027 Resolve on the same cycle the counter reaches MAX_WAIT shall win: REDIRECT is taken, and wd_err is not set.
REQ-028 In REDIRECT, NPC shall be the captured target if taken, else PC+1; REDIRECT->IDLE unconditionally after one cycle.
REQ-029 br_resolve in IDLE or REDIRECT shall be ignored; br_decode, j_valid and jr_valid in WAIT or REDIRECT shall be ignored.
REQ-030 hazard shall not alter WAIT or REDIRECT sequencing.
REQ-031 bubble_cnt shall increment on each edge where state=WAIT and shall saturate at all-ones.
REQ-032 Latency: branch decode to redirected NPC = (WAIT cycles) + 1 cycle; the minimum is 2 cycles.

Reset
REQ-033 Reset shall force, asynchronously: state=IDLE, wait counter=0, captured taken=0, captured target=0, wd_err=0, bubble_cnt=0.
REQ-034 During and after Reset, BranchBubble=0 and NPC=PC+1 (combinational from PC).
REQ-035 Reset asserted in WAIT shall drop BranchBubble immediately, without waiting for the clock edge.

Structure
REQ-036 State encodings (IDLE=2'd0, WAIT=2'd1, REDIRECT=2'd2) and the reset vector word address 30'h00000C00 shall reside in the shared datapath package.
REQ-037 The saturating counter shall be a sub-module sat_cnt parameterised by width.

Verification
REQ-038 Reset, PC=30'hC00 -> NPC=30'hC01, BranchBubble=0, bubble_cnt=0.
REQ-039 br_decode at PC=30'hC04, resolve taken with target 30'hC40 after 2 WAIT cycles -> BranchBubble high 2 cycles; NPC=30'hC40 in REDIRECT; bubble_cnt=2.
REQ-040 br_decode with hazard=1 for 1 cycle, then hazard=0 -> WAIT entered one cycle later; resolve not-taken at PC=30'hC08 -> NPC=30'hC09.
REQ-041 PC=30'h3000C00, j_valid=1, j_index=26'h0000100, jr_valid=1, jr_target=30'h1234 -> NPC=30'h1234; with jr_valid=0 -> NPC=30'h0000100.
REQ-042 MAX_WAIT=8, no resolve -> IDLE after 8 cycles, wd_err=1; a later Reset clears it; a resolve on cycle 8 -> REDIRECT, wd_err=0.
REQ-043 Reset asserted mid-WAIT between clock edges -> BranchBubble=0 immediately; PC=30'h3FFFFFFF in IDLE -> NPC=30'h0.
